dir_offset_decoder: RTL and testbench

//  Inverse of the dir18 offset ROMs: turns a stream of 5-bit signed bin offsets (+8..-7) back into absolute 4-bit

---
 rtl/dir_offset_decoder_if.sv | 34 +++
 rtl/dir_offset_decoder.sv | 135 +++++++++++++
 tb/tb_dir_offset_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dir_offset_decoder_if.sv
// Handshake bundle for dir_offset_decoder: offset input stream, decoded output stream and histogram dump stream.
interface dir_offset_decoder_if #(
  parameter int unsigned OFF_W = 5,
  parameter int unsigned DIR_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [OFF_W-1:0] in_off;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DIR_W-1:0] out_dir;
  logic             out_err;
  logic             out_last;
  logic [CNT_W-1:0] err_cnt;
  logic             hist_valid;
  logic             hist_ready;
  logic [DIR_W-1:0] hist_bin;
  logic [CNT_W-1:0] hist_cnt;
  logic             hist_last;

  modport master (
    output in_valid, in_off, in_last, out_ready, hist_ready,
    input  in_ready, out_valid, out_dir, out_err, out_last, err_cnt,
           hist_valid, hist_bin, hist_cnt, hist_last
  );

  modport slave (
    input  in_valid, in_off, in_last, out_ready, hist_ready,
    output in_ready, out_valid, out_dir, out_err, out_last, err_cnt,
           hist_valid, hist_bin, hist_cnt, hist_last
  );
endinterface

// File: rtl/dir_offset_decoder.sv
// Decodes signed 5-bit bin offsets (+8..-7) into absolute 4-bit orientation bins, one beat per cycle.
// Optional per-keypoint direction histogram dump enabled by defining DIR_HIST_EN.
module dir_offset_decoder #(
  parameter int unsigned OFF_W = 5,
  parameter int unsigned DIR_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dir_offset_decoder_if.slave   bus
);

  localparam int unsigned NBINS = 1 << DIR_W;

  logic             in_range_c;
  logic [OFF_W-1:0] d5_c;
  logic [DIR_W-1:0] dir_c;
  logic             out_free_c;
  logic             run_c;
  logic             acc_c;

  // Offsets 0x19..0x1F are -7..-1; 0x09..0x18 has no bin.
  always_comb begin
    in_range_c = (bus.in_off >= OFF_W'(5'h19)) || (bus.in_off <= OFF_W'(5'h08));
    d5_c       = OFF_W'(8) - bus.in_off;
    dir_c      = in_range_c ? d5_c[DIR_W-1:0] : '0;
  end

  assign out_free_c   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = out_free_c && run_c;
  assign acc_c        = bus.in_valid && bus.in_ready;

  // Output stage: load on accept, otherwise drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_dir   <= '0;
      bus.out_err   <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (acc_c) begin
      bus.out_valid <= 1'b1;
      bus.out_dir   <= dir_c;
      bus.out_err   <= !in_range_c;
      bus.out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_cnt <= '0;
    end else if (acc_c && !in_range_c && (bus.err_cnt != '1)) begin
      bus.err_cnt <= bus.err_cnt + CNT_W'(1);
    end
  end

`ifdef DIR_HIST_EN
  typedef enum logic {RUN, DUMP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_c;
  logic [DIR_W-1:0] load_idx_c;
  logic [CNT_W-1:0] hcnt_q [NBINS];

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Dump walks the bins through the hist_* register; a bin is cleared when it is loaded for sending.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    load_idx_c = '0;
    case (state_q)
      RUN: begin
        if (acc_c && bus.in_last) state_d = DUMP;
      end
      DUMP: begin
        if (!bus.hist_valid) begin
          load_c = 1'b1;
        end else if (bus.hist_ready) begin
          if (bus.hist_last) begin
            state_d = RUN;
          end else begin
            load_c     = 1'b1;
            load_idx_c = bus.hist_bin + DIR_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign run_c = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NBINS); i++) hcnt_q[i] <= '0;
    end else if (load_c) begin
      hcnt_q[load_idx_c] <= '0;
    end else if (acc_c && in_range_c && (hcnt_q[dir_c] != '1)) begin
      hcnt_q[dir_c] <= hcnt_q[dir_c] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hist_valid <= 1'b0;
      bus.hist_bin   <= '0;
      bus.hist_cnt   <= '0;
      bus.hist_last  <= 1'b0;
    end else if (load_c) begin
      bus.hist_valid <= 1'b1;
      bus.hist_bin   <= load_idx_c;
      bus.hist_cnt   <= hcnt_q[load_idx_c];
      bus.hist_last  <= (load_idx_c == '1);
    end else if (bus.hist_valid && bus.hist_ready) begin
      bus.hist_valid <= 1'b0;
    end
  end
`else
  logic unused_hist_ready;

  assign run_c             = 1'b1;
  assign unused_hist_ready = bus.hist_ready;
  assign bus.hist_valid    = 1'b0;
  assign bus.hist_bin      = '0;
  assign bus.hist_cnt      = '0;
  assign bus.hist_last     = 1'b0;
`endif

endmodule

// File: tb/tb_dir_offset_decoder.sv
// Self-checking bench for dir_offset_decoder against an arithmetic reference of the offset-to-bin rule.
module tb_dir_offset_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dir_offset_decoder_if bus ();

  dir_offset_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  bit exp_valid;
  int exp_dir;
  bit exp_err;
  bit exp_last;
  int exp_ecnt;
  bit dump;
  int didx;
  int hcnt [16];
  int seen [16];
  int seen_last;
  int acc_n;
  int drn_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offset is a signed bin delta; the absolute bin is 8 minus it, valid only for deltas -7..+8.
  function automatic void ref_decode(input logic [4:0] off, output bit ok, output int dir);
    int s;
    s   = (off >= 5'd16) ? int'(off) - 32 : int'(off);
    ok  = (s >= -7) && (s <= 8);
    dir = ok ? 8 - s : 0;
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_dir = 0; exp_err = 0; exp_last = 0; exp_ecnt = 0;
    dump = 0; didx = 0;
    for (int i = 0; i < 16; i++) hcnt[i] = 0;
  endtask

  task automatic cycle(input bit v, input logic [4:0] off, input bit l, input bit ordy,
                       input bit hrdy, input bit r, output bit took);
    bit acc, drain, hx, ok;
    int dir;
    bus.in_valid   = v;
    bus.in_off     = off;
    bus.in_last    = l;
    bus.out_ready  = ordy;
    bus.hist_ready = hrdy;
    rst            = r;
    #1;
    chk("in_ready", bus.in_ready, ((!exp_valid || ordy) && !dump) ? 1 : 0);
    chk("out_valid", bus.out_valid, exp_valid);
    if (exp_valid) begin
      chk("out_dir", bus.out_dir, exp_dir);
      chk("out_err", bus.out_err, exp_err);
      chk("out_last", bus.out_last, exp_last);
    end
    chk("err_cnt", bus.err_cnt, exp_ecnt);
    hx = 0;
`ifdef DIR_HIST_EN
    if (!dump) begin
      chk("hist_idle", bus.hist_valid, 0);
    end else if (bus.hist_valid) begin
      chk("hist_bin", bus.hist_bin, didx);
      chk("hist_cnt", bus.hist_cnt, hcnt[didx]);
      chk("hist_last", bus.hist_last, (didx == 15) ? 1 : 0);
      hx = hrdy;
    end
`else
    chk("hist_valid_tie", bus.hist_valid, 0);
    chk("hist_cnt_tie", bus.hist_cnt, 0);
`endif
    acc   = v && (!exp_valid || ordy) && !dump;
    drain = exp_valid && ordy;
    took  = acc && !r;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      return;
    end
    if (drain) drn_n++;
    if (hx) begin
      seen[didx] = hcnt[didx];
      if (didx == 15) seen_last++;
      hcnt[didx] = 0;
      if (didx == 15) dump = 0;
      else didx++;
    end
    if (acc) begin
      acc_n++;
      ref_decode(off, ok, dir);
      exp_valid = 1; exp_dir = dir; exp_err = !ok; exp_last = l;
      if (!ok && exp_ecnt < 255) exp_ecnt++;
`ifdef DIR_HIST_EN
      if (ok && hcnt[dir] < 255) hcnt[dir]++;
      if (l) begin dump = 1; didx = 0; end
`endif
    end else if (drain) begin
      exp_valid = 0;
    end
  endtask

  task automatic run_dump(input bit toggle);
    bit t;
    for (int k = 0; k < 200 && dump; k++) cycle(0, 5'd0, 0, 1, toggle ? k[0] : 1'b1, 0, t);
    chk("dump_done", dump, 0);
  endtask

  initial begin
    bit t;
    logic [4:0] off;
    bit l;
    int idx;
    logic [4:0] t3 [4];
    model_reset();
    acc_n = 0; drn_n = 0; seen_last = 0;
    bus.in_valid = 0; bus.in_off = 0; bus.in_last = 0; bus.out_ready = 1; bus.hist_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_dir", bus.out_dir, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_hist_valid", bus.hist_valid, 0);

    // Directed decode of the range corners.
    cycle(1, 5'h08, 0, 1, 1, 0, t); chk("t1_dir_08", bus.out_dir, 0);
    cycle(1, 5'h00, 0, 1, 1, 0, t); chk("t1_dir_00", bus.out_dir, 8);
    cycle(1, 5'h19, 0, 1, 1, 0, t); chk("t1_dir_19", bus.out_dir, 15);
    cycle(1, 5'h1F, 0, 1, 1, 0, t); chk("t1_dir_1f", bus.out_dir, 9);
    chk("t1_err", bus.out_err, 0);

    cycle(1, 5'h10, 0, 1, 1, 0, t); chk("t2_err_10", bus.out_err, 1); chk("t2_dir_10", bus.out_dir, 0);
    cycle(1, 5'h09, 0, 1, 1, 0, t); chk("t2_err_09", bus.out_err, 1); chk("t2_dir_09", bus.out_dir, 0);
    chk("t2_cnt2", bus.err_cnt, 2);
    for (int i = 0; i < 300; i++) cycle(1, 5'($urandom_range(9, 24)), 0, 1, 1, 0, t);
    chk("t2_sat", bus.err_cnt, 255);
    cycle(0, 5'd0, 0, 1, 1, 0, t);

    // Backpressure with a pending stream; each beat is held until accepted.
    t3[0] = 5'h01; t3[1] = 5'h02; t3[2] = 5'h1A; t3[3] = 5'h05;
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      cycle(1, t3[idx], 0, (k >= 1 && k <= 5) ? 1'b0 : 1'b1, 1, 0, t);
      if (t) idx++;
    end
    chk("t3_all_sent", idx, 4);
    cycle(0, 5'd0, 0, 1, 1, 0, t);
    chk("t3_no_loss", drn_n, acc_n);

`ifdef DIR_HIST_EN
    for (int i = 0; i < 16; i++) seen[i] = -1;
    cycle(1, 5'h08, 0, 1, 1, 0, t);
    cycle(1, 5'h08, 0, 1, 1, 0, t);
    cycle(1, 5'h07, 1, 1, 1, 0, t);
    run_dump(0);
    chk("t4_bin0", seen[0], 2);
    chk("t4_bin1", seen[1], 1);
    chk("t4_bin9", seen[9], 0);
    chk("t4_last", seen_last, 1);
    cycle(1, 5'h00, 1, 1, 1, 0, t);
    run_dump(1);
    chk("t5_bin8", seen[8], 1);
    chk("t5_bin0", seen[0], 0);

    cycle(1, 5'h03, 0, 1, 1, 0, t);
    cycle(1, 5'h1C, 1, 1, 1, 0, t);
    for (int k = 0; k < 100 && !(bus.hist_valid && bus.hist_bin == 4'd6); k++) cycle(0, 5'd0, 0, 1, 1, 0, t);
    chk("t6_at_bin6", bus.hist_bin, 6);
    cycle(0, 5'd0, 0, 1, 1, 1, t);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_hist_valid", bus.hist_valid, 0);
    chk("t6_hist_bin", bus.hist_bin, 0);
    chk("t6_err_cnt", bus.err_cnt, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    cycle(1, 5'h08, 1, 1, 1, 0, t);
    run_dump(0);
    chk("t6_bin0", seen[0], 1);
    chk("t6_bin5", seen[5], 0);
`endif

    // Random traffic with random backpressure on both output streams.
    off = 5'($urandom); l = ($urandom_range(0, 7) == 0);
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 3) != 0, off, l, $urandom_range(0, 2) != 0, 1'($urandom), 0, t);
      if (t) begin off = 5'($urandom); l = ($urandom_range(0, 7) == 0); end
    end
    for (int k = 0; k < 200 && (exp_valid || dump); k++) cycle(0, 5'd0, 0, 1, 1, 0, t);
    chk("rand_drained", drn_n, acc_n);

    cycle(0, 5'd0, 0, 1, 1, 1, t);
    chk("end_rst_err_cnt", bus.err_cnt, 0);
    chk("end_rst_out_valid", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
